fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch and sequencing stage directly upstream of the decoder.
- Holds the PC and requests 9-bit instructions from instruction memory with a req/ack handshake.
- Presents each instruction to the decoder with a one-cycle decoder_en strobe, then waits for the execute step to finish.
- Computes the next PC from the decoder's branch/branchi/jump/done results.

Parameters:
PC_W, 8, PC and instruction-memory address width
RESET_PC, 0, PC value loaded on reset and on restart
IMM_W, 6, width of decoder immediate; two's-complement branch offset
IMEM_DEPTH, 256, number of valid instruction words; used only by the optional bounds check

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins fetching from RESET_PC
imem_req  out  1  instruction-memory read request
imem_addr  out  PC_W  read address, equal to pc while imem_req is high
imem_rdata  in  9  instruction word, valid when imem_ack is high
imem_ack  in  1  read complete; may assert in the same cycle as imem_req
inst  out  9  latched instruction, stable from DEC until the next fetch completes
decoder_en  out  1  one-cycle strobe to the decoder
pc  out  PC_W  address of the instruction currently held in inst
branch  in  1  decoder: register-target branch taken
branchi  in  1  decoder: immediate-offset branch taken
jump  in  1  decoder: unconditional jump flag; informational, already folded into branchi
immediate  in  IMM_W  decoder immediate field
target  in  PC_W  register-file value used as the branch target
done  in  1  decoder halt flag
step_done  in  1  execute stage finished the current instruction
halted  out  1  high while in HALT
fault  out  1  bounds fault; driven only when the optional feature is compiled in, tied 0 otherwise

Behaviour:
Reset values:
- pc and imem_addr = RESET_PC.
- imem_req = 0, inst = 9'h000, decoder_en = 0, halted = 0, fault = 0.
- State = IDLE.
- rst_n low at any point, including mid-handshake, forces reset state immediately and drops imem_req.

FSM states and transitions:
- IDLE: wait for start, then load pc = RESET_PC and go to REQ.
- REQ: imem_req = 1, imem_addr = pc. On imem_ack, latch inst <= imem_rdata, drop imem_req next cycle, go to DEC. With zero-wait ack, REQ lasts one cycle.
- DEC: decoder_en = 1 for exactly this cycle, then go to WAIT. Decoder outputs become valid on the following edge.
- WAIT: hold until step_done = 1. step_done is ignored during DEC. On step_done, sample decoder outputs and compute the next PC with this priority:
  1. done = 1: go to HALT.
  2. branch = 1: next pc = target.
  3. branchi = 1: next pc = pc + sign_extend(immediate), offset relative to the branching instruction.
  4. Otherwise: next pc = pc + 1.
  Then go to REQ.
- HALT: halted = 1, no requests. A start pulse clears halted, sets pc = RESET_PC, and goes to REQ.

Arithmetic and boundary rules:
- All PC arithmetic is modulo 2^PC_W: wrap-around is silent.
- Negative offsets are allowed.
- start outside IDLE/HALT is ignored.
- imem_ack outside REQ is ignored.
- branch and branchi both high: branch wins.
- done together with any branch: done wins.
- pc is unchanged from the fetch address until the next-PC update in WAIT.

Optional Feature:
Macro: FETCH_BOUNDS_CHECK_EN
- Defined: if the computed next pc is >= IMEM_DEPTH, go to HALT with fault = 1 and halted = 1, and issue no request. fault clears only on reset or start.
- Undefined: no check; fault is tied to 0; addresses wrap per PC_W.

Decomposition:
- Shared package cirno_fetch_pkg: fetch state enum (IDLE, REQ, DEC, WAIT, HALT), INST_W = 9, NOP encoding 9'h000.
- One natural sub-module: fetch_pc_next. Purely combinational; inputs pc, branch, branchi, done, immediate, target; outputs next_pc and halt_req. Lets the priority and sign-extension rules be verified in isolation.

Test Plan:
1. Reset then start, memory acks after 2 cycles with 9'h0C1 at addr 0 → decoder_en high for one cycle, inst = 9'h0C1, pc = 0; on step_done, imem_addr = 1.
2. Zero-wait ack, branchi = 1 with immediate = 6'b111110 at pc = 5 → next imem_addr = 3; with immediate = 6'd4 at pc = 254, PC_W = 8 → imem_addr = 2 (wrap).
3. branch = 1 and branchi = 1 together with target = 8'h40, at step_done → imem_addr = 8'h40.
4. done = 1 at step_done → halted = 1 and imem_req stays 0 for 20 cycles; start pulse → imem_addr = RESET_PC, halted = 0.
5. rst_n pulsed low while in REQ with ack pending → imem_req = 0 immediately, pc = RESET_PC; a late ack is ignored and no decoder_en occurs.
6. With FETCH_BOUNDS_CHECK_EN and IMEM_DEPTH = 16, pc = 15, no branch → fault = 1, halted = 1, no request to addr 16. Without the macro → fetch from addr 16.

Source files
------------

// File: rtl/cirno_fetch_pkg.sv
// ============================================================================
// Module      : cirno_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               fetch FSM state encoding, instruction width, NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cirno_fetch_pkg;

    // Instruction word width delivered by instruction memory
    localparam int INST_W = 9;

    // Encoding held in the instruction latch while nothing has been fetched
    localparam logic [INST_W-1:0] NOP_INST = 9'h000;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_DEC  = 3'd2,
        ST_WAIT = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_t;

endpackage : cirno_fetch_pkg

`default_nettype wire

// File: rtl/fetch_pc_next.sv
// ============================================================================
// Module      : fetch_pc_next
// Description : Combinational next-PC selection. Priority is
//               done > branch (register target) > branchi (PC-relative,
//               sign-extended immediate) > sequential PC + 1.
//               All arithmetic wraps modulo 2^PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_next
    import cirno_fetch_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IMM_W = 6
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             branch,
    input  logic             branchi,
    input  logic             done,
    input  logic [IMM_W-1:0] immediate,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  next_pc,
    output logic             halt_req
);

    logic [PC_W-1:0] w_offset;

    // Bring the two's-complement immediate to PC width
    generate
        if (PC_W > IMM_W) begin : g_sext_wide
            assign w_offset = {{(PC_W-IMM_W){immediate[IMM_W-1]}}, immediate};
        end else begin : g_sext_narrow
            assign w_offset = immediate[PC_W-1:0];
        end
    endgenerate

    // Select the next PC; done is reported separately and overrides any branch
    always_comb begin
        halt_req = done;
        next_pc  = pc + {{(PC_W-1){1'b0}}, 1'b1};
        if (branch) begin
            next_pc = target;
        end else if (branchi) begin
            next_pc = pc + w_offset;
        end
    end

endmodule : fetch_pc_next

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch/sequencing stage. Requests instructions
//               over a req/ack handshake, strobes the decoder for one cycle,
//               waits for the execute step and advances the PC.
//               Optional build macro FETCH_BOUNDS_CHECK_EN halts with fault
//               when the next PC falls outside IMEM_DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import cirno_fetch_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int RESET_PC   = 0,
    parameter int IMM_W      = 6,
    parameter int IMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [INST_W-1:0] inst,
    output logic              decoder_en,
    output logic [PC_W-1:0]   pc,
    input  logic              branch,
    input  logic              branchi,
    input  logic              jump,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [PC_W-1:0]   target,
    input  logic              done,
    input  logic              step_done,
    output logic              halted,
    output logic              fault
);

    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

    fetch_state_t      r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_req;
    logic [INST_W-1:0] r_inst;
    logic              r_dec_en;
    logic              r_halted;
    logic              r_fault;

    logic [PC_W-1:0]   w_next_pc;
    logic              w_halt_req;
    logic              w_out_of_range;
    logic              w_unused;

    fetch_pc_next #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_pc_next (
        .pc        (r_pc),
        .branch    (branch),
        .branchi   (branchi),
        .done      (done),
        .immediate (immediate),
        .target    (target),
        .next_pc   (w_next_pc),
        .halt_req  (w_halt_req)
    );

`ifdef FETCH_BOUNDS_CHECK_EN
    assign w_out_of_range = (32'(w_next_pc) >= 32'(IMEM_DEPTH));
    assign fault          = r_fault;
    // jump is already folded into branchi by the decoder
    assign w_unused       = jump;
`else
    assign w_out_of_range = 1'b0;
    assign fault          = 1'b0;
    assign w_unused       = jump ^ r_fault ^ (IMEM_DEPTH == 0);
`endif

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign decoder_en = r_dec_en;
    assign halted     = r_halted;

    // Fetch sequencer: all outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= c_reset_pc;
            r_req    <= 1'b0;
            r_inst   <= NOP_INST;
            r_dec_en <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_dec_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pc    <= c_reset_pc;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        r_inst   <= imem_rdata;
                        r_req    <= 1'b0;
                        r_dec_en <= 1'b1;
                        r_state  <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    // Decoder results land on this edge; step_done not looked at yet
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (step_done) begin
                        if (w_halt_req) begin
                            r_halted <= 1'b1;
                            r_state  <= ST_HALT;
                        end else if (w_out_of_range) begin
                            r_halted <= 1'b1;
                            r_fault  <= 1'b1;
                            r_state  <= ST_HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_req   <= 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        r_halted <= 1'b0;
                        r_fault  <= 1'b0;
                        r_pc     <= c_reset_pc;
                        r_req    <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : fetch_unit

`default_nettype wire
